// File: rtl/cpu_pkg.sv
// Shared pipeline types for the LEGv8 core: control word layout, zero-register id, stage FSM states.
// No logic; types and constants only.
package cpu_pkg;

    localparam logic [4:0] XZR = 5'd31;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       set_flags;
        logic [2:0] alu_op;
        logic       valid;
    } ctrl_t;

    localparam ctrl_t BUBBLE_CTRL = '0;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } stage_state_e;

endpackage

// File: rtl/sat_counter.sv
// Unsigned event counter that sticks at its maximum value instead of wrapping.
// Latency: count reflects an event one cycle after inc is seen.
// Backpressure: en = 0 freezes the count regardless of inc.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (en && inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and stall/flush event counters.
// Latency: one cycle from *_ID inputs to *_EX outputs; PCWrite/IF_ID_Write are combinational.
// Backpressure: hold freezes all state; a load-use hazard drops PCWrite/IF_ID_Write for one cycle.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              hold,
    input  logic              flush,
    input  logic [4:0]        Rn_ID,
    input  logic [4:0]        Rm_ID,
    input  logic [4:0]        Rd_ID,
    input  logic              uses_rn_ID,
    input  logic              uses_rm_ID,
    input  logic [DATA_W-1:0] rdA_ID,
    input  logic [DATA_W-1:0] rdB_ID,
    input  logic [DATA_W-1:0] imm_ID,
    input  logic [9:0]        ctrl_ID,
    output logic [4:0]        Rn_EX,
    output logic [4:0]        Rm_EX,
    output logic [4:0]        Rd_EX,
    output logic [DATA_W-1:0] rdA_EX,
    output logic [DATA_W-1:0] rdB_EX,
    output logic [DATA_W-1:0] imm_EX,
    output logic [9:0]        ctrl_EX,
    output logic              PCWrite,
    output logic              IF_ID_Write,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    ctrl_t        ctrl_ex_q;
    ctrl_t        ctrl_id_s;
    stage_state_e state_q, state_d;
    logic         luh;
    logic         stall_req;
    logic         load_bubble;
    logic         load_id;

    assign ctrl_id_s = ctrl_t'(ctrl_ID);
    assign ctrl_EX   = ctrl_ex_q;

    // A bubble in EX (Rd = XZR, mem_read = 0) can never raise luh, so stalls are one cycle long.
    assign luh = ctrl_ex_q.mem_read && ctrl_ex_q.valid && (Rd_EX != XZR) &&
                 ((uses_rn_ID && (Rn_ID == Rd_EX)) || (uses_rm_ID && (Rm_ID == Rd_EX)));

    assign stall_req   = luh && !flush;
    assign PCWrite     = !stall_req;
    assign IF_ID_Write = !stall_req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!hold) begin
            case (state_q)
                RUN:     if (stall_req) state_d = STALL;
                STALL:   state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        load_bubble = 1'b0;
        load_id     = 1'b0;
        if (!hold) begin
            load_bubble = flush || luh;
            load_id     = !(flush || luh);
        end
    end

    // Data fields are left untouched on a bubble; only control and register ids are squashed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_ex_q <= BUBBLE_CTRL;
            Rn_EX     <= XZR;
            Rm_EX     <= XZR;
            Rd_EX     <= XZR;
            rdA_EX    <= '0;
            rdB_EX    <= '0;
            imm_EX    <= '0;
        end else if (load_bubble) begin
            ctrl_ex_q <= BUBBLE_CTRL;
            Rn_EX     <= XZR;
            Rm_EX     <= XZR;
            Rd_EX     <= XZR;
        end else if (load_id) begin
            ctrl_ex_q <= ctrl_id_s;
            Rn_EX     <= Rn_ID;
            Rm_EX     <= Rm_ID;
            Rd_EX     <= Rd_ID;
            rdA_EX    <= rdA_ID;
            rdB_EX    <= rdB_ID;
            imm_EX    <= imm_ID;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (!hold),
        .inc     (stall_req),
        .count   (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (!hold),
        .inc     (flush),
        .count   (flush_cnt)
    );

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the pipelined LEGv8 core, with integrated load-use hazard detection. It captures decoded operands and control from ID and presents them to EX, where the forwarding unit consumes `Rn_EX`, `Rm_EX` and `Rd_EX`. It stalls PC and IF/ID for exactly one cycle on a load-use dependency and inserts bubbles on stall or flush. Saturating stall and flush counters are included for performance debug.

## Interface
- `DATA_W`, 64: datapath width.
- `CNT_W`, 16: width of the performance counters.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `hold` in 1: global freeze from the memory system; all state holds.
- `flush` in 1: squash the ID instruction from a taken branch; forces a bubble.
- `Rn_ID`, `Rm_ID`, `Rd_ID` in 5 each: register fields from decode.
- `uses_rn_ID`, `uses_rm_ID` in 1 each: the ID instruction reads `Rn` / `Rm`.
- `rdA_ID`, `rdB_ID`, `imm_ID` in `DATA_W` each: register-file reads and the extended immediate.
- `ctrl_ID` in 10: {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, SetFlags, ALUOp[2:0], valid}.
- `Rn_EX`, `Rm_EX`, `Rd_EX` out 5 each: registered fields.
- `rdA_EX`, `rdB_EX`, `imm_EX` out `DATA_W` each: registered data.
- `ctrl_EX` out 10: registered control; a bubble is all zeros.
- `PCWrite`, `IF_ID_Write` out 1 each: deasserted during a load-use stall.
- `stall_cnt`, `flush_cnt` out `CNT_W` each: saturating event counters.

## Operation
- **Hazard condition `luh`**: `ctrl_EX.MemRead && ctrl_EX.valid && Rd_EX != 31 && ((uses_rn_ID && Rn_ID == Rd_EX) || (uses_rm_ID && Rm_ID == Rd_EX))`.
- **FSM states RUN and STALL.** Transitions are evaluated only when `hold` = 0.
  - RUN → STALL on `luh && !flush`.
  - STALL → RUN unconditionally. The bubble just inserted makes `luh` false, so a second consecutive stall is illegal; the bench asserts this.
- **Register update priority, highest first:**
  1. `hold`: freeze everything, including the FSM and counters.
  2. `flush`: load a bubble.
  3. `luh`: load a bubble.
  4. Otherwise: load all `*_ID` inputs.
- **Bubble contents**: `ctrl_EX` = 0. `Rn_EX`, `Rm_EX` and `Rd_EX` = 31, so forwarding never matches a bubble. Data fields hold their old values (don't-care).
- **`PCWrite` / `IF_ID_Write`**: combinational, = `!(luh && !flush)`. They are not gated by `hold`; the upstream stages apply `hold` themselves.
- **Simultaneous `flush` and `luh`**: flush wins. Bubble inserted, no stall, no stall count, FSM stays in RUN.
- **`stall_cnt`**: +1 on each non-held cycle with `luh && !flush`.
- **`flush_cnt`**: +1 on each non-held cycle with `flush`.
- **Counter arithmetic**: unsigned; both saturate at 2^`CNT_W`−1 and do not wrap.

## Timing
- Latency: one cycle from ID inputs to EX outputs.
- Reset (asynchronous assert, synchronous release):
  - FSM = RUN, `ctrl_EX` = 0, `Rn_EX`/`Rm_EX`/`Rd_EX` = 31.
  - `rdA_EX`, `rdB_EX`, `imm_EX` = 0; both counters = 0.
  - `PCWrite` = `IF_ID_Write` = 1, because `luh` is false with the bubble state.
- Reset mid-stall: the next cycle is RUN with a bubble in EX; the load is lost by design (the pipeline restarts).
- Load-use sequence:
  - Cycle n: the load is in EX and the dependent instruction is in ID, so `luh` = 1. `PCWrite` = 0 in cycle n.
  - Edge n→n+1: bubble enters EX; FSM → STALL.
  - Cycle n+1: the dependent instruction is re-presented with `luh` = 0.
  - Edge n+1→n+2: the dependent instruction enters EX; the load is now in MEM/WB and is forwarded.
- `hold` during STALL: the FSM remains in STALL until `hold` drops.

## Structure
- Shared `cpu_pkg`:
  - `ctrl_t` packed struct matching the `ctrl_ID` layout.
  - `XZR` = 5'd31 constant.
  - `BUBBLE_CTRL` constant.
  - `stage_state_e` enum {RUN, STALL}.
- Sub-module `sat_counter` (parameter `CNT_W`, with `inc`, `en`, `reset_n`), instantiated twice.
- Hazard compare, FSM and pipeline register stay in the top module.

## Test plan
- **Reset:** drive `reset_n` = 0 mid-cycle → outputs immediately become `ctrl_EX` = 0, `Rd_EX` = 31, counters 0, `PCWrite` = 1.
- **Load-use:** LDUR X2 followed by ADD X3, X2, X4 (`uses_rn`) → exactly one cycle with `PCWrite` = `IF_ID_Write` = 0, one bubble, ADD in EX two cycles after the load; `stall_cnt` = 1.
- **No false stalls:**
  - LDUR X31 followed by a reader of X31 → no stall.
  - LDUR X2 followed by an instruction with `uses_rm` = 0 and `Rm_ID` = 2 → no stall.
- **Flush priority:** `flush` and `luh` in the same cycle → bubble, `PCWrite` = 1, `flush_cnt` +1, `stall_cnt` unchanged, FSM stays in RUN.
- **Hold:** `hold` = 1 for 3 cycles during STALL → EX outputs, FSM and counters frozen; on release, the sequence completes as in the load-use scenario.
- **Saturation:** with `CNT_W` = 4, issue 20 load-use pairs → `stall_cnt` = 15 and stays there.
